// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
    localparam int PC_W        = 16;
    localparam int INSTR_W_DEF = 9;

    localparam logic [INSTR_W_DEF-1:0] NOP_OP_DEF  = 9'h000;
    localparam logic [INSTR_W_DEF-1:0] HALT_OP_DEF = 9'h1FF;

    typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/sat_counter16.sv
// 16-bit up counter with increment enable that sticks at all-ones.
module sat_counter16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] count
);
    logic [15:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != 16'hFFFF)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: owns the PC, drives imem and fills the IF/ID register.
module fetch_pc_stage
    import fetch_pkg::*;
#(
    parameter int                  INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0]     RESET_PC = 16'h0000,
    parameter logic [INSTR_W-1:0]  HALT_OP  = HALT_OP_DEF,
    parameter logic [INSTR_W-1:0]  NOP_OP   = NOP_OP_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    target_in,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic               ifid_valid,
    output logic               halted,
    output logic [15:0]        fetch_count
);
    fetch_state_t       state_reg, state_next;
    logic [PC_W-1:0]    pc_reg, pc_next;
    logic [INSTR_W-1:0] instr_reg, instr_next;
    logic [PC_W-1:0]    ipc_reg, ipc_next;
    logic               valid_reg, valid_next;
    logic               halted_reg, halted_next;
    logic               count_inc;

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        instr_next  = instr_reg;
        ipc_next    = ipc_reg;
        valid_next  = valid_reg;
        halted_next = halted_reg;
        count_inc   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                // A redirect squashes this cycle's fetch, even over a stall.
                if (branch_taken) begin
                    pc_next    = target_in;
                    instr_next = NOP_OP;
                    ipc_next   = pc_reg;
                    valid_next = 1'b0;
                end else if (!stall) begin
                    instr_next = imem_rdata;
                    ipc_next   = pc_reg;
                    valid_next = 1'b1;
                    count_inc  = 1'b1;
                    if (imem_rdata == HALT_OP) begin
                        state_next  = HALT;
                        halted_next = 1'b1;
                    end else begin
                        pc_next = pc_reg + 16'd1;
                    end
                end
            end
            HALT: begin
                valid_next = 1'b0;
                instr_next = NOP_OP;
                if (start) begin
                    pc_next     = RESET_PC;
                    state_next  = RUN;
                    halted_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            pc_reg     <= RESET_PC;
            instr_reg  <= NOP_OP;
            ipc_reg    <= '0;
            valid_reg  <= 1'b0;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            instr_reg  <= instr_next;
            ipc_reg    <= ipc_next;
            valid_reg  <= valid_next;
            halted_reg <= halted_next;
        end
    end

    sat_counter16 u_fetch_count (
        .clk   (clk),
        .reset (reset),
        .inc   (count_inc),
        .count (fetch_count)
    );

    assign imem_addr  = pc_reg;
    assign ifid_instr = instr_reg;
    assign ifid_pc    = ipc_reg;
    assign ifid_valid = valid_reg;
    assign halted     = halted_reg;
endmodule
